// File: rtl/port_uart_tx.sv
// port_uart_tx: CPU output-port peripheral that queues bytes written to
// DATA_ADDR in a small FIFO and shifts them out as 8N1 UART frames on tx.
// A status word (overflow, fifo_full, busy) is readable at STATUS_ADDR.
module port_uart_tx #(
  parameter logic [15:0] DATA_ADDR    = 16'h0002,
  parameter logic [15:0] STATUS_ADDR  = 16'h0003,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] port_wdata,
  output logic [15:0] status,
  output logic        tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [BW-1:0]   baud_r, baud_s;
  logic [2:0]      bit_r, bit_s;
  logic [7:0]      shift_r, shift_s;
  logic            tx_r, tx_s;

  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [PW:0]     cnt_r, cnt_s;
  logic            overflow_r, overflow_s;

  logic            empty_s, full_s, busy_s, baud_last_s;
  logic            push_req_s, push_ok_s, pop_s, ovf_clr_s;
  logic [7:0]      head_s;
  logic            unused_s;

  // Upper half of the CPU data word carries nothing for this port.
  assign unused_s = ^port_wdata[15:8];

  assign empty_s     = (cnt_r == '0);
  assign full_s      = (cnt_r == DEPTH_C);
  assign busy_s      = (state_r != ST_IDLE) | ~empty_s;
  assign baud_last_s = (baud_r == BAUD_LAST);
  assign head_s      = mem_r[rd_ptr_r];

  assign push_req_s  = cpu_write & (cpu_addr == DATA_ADDR);
  assign ovf_clr_s   = cpu_read & (cpu_addr == STATUS_ADDR);
  // A full FIFO can still take a byte when the head leaves on the same edge.
  assign push_ok_s   = push_req_s & (~full_s | pop_s);

  assign status = {13'b0, overflow_r, full_s, busy_s};
  assign tx     = tx_r;

  // Next-state, baud/bit counters, shifter and pop request for the frame FSM.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    pop_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_s = '0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_s = head_s;
          bit_s   = 3'd0;
          state_s = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          baud_s  = '0;
          state_s = ST_DATA;
        end else begin
          baud_s  = baud_r + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_s  = '0;
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            bit_s   = 3'd0;
            state_s = ST_STOP;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last_s) begin
          baud_s = '0;
          if (!empty_s) begin
            // Next byte already waiting: chain straight into its start bit.
            pop_s   = 1'b1;
            shift_s = head_s;
            bit_s   = 3'd0;
            state_s = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          baud_s = baud_r + BW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        baud_s  = '0;
        bit_s   = 3'd0;
      end
    endcase
  end

  // Line level for the state being entered, so tx can be registered.
  always_comb begin
    tx_s = 1'b1;
    case (state_s)
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = shift_s[0];
      ST_STOP:  tx_s = 1'b1;
      ST_IDLE:  tx_s = 1'b1;
      default:  tx_s = 1'b1;
    endcase
  end

  // FIFO occupancy and sticky overflow; a same-cycle set beats a clear.
  always_comb begin
    cnt_s      = cnt_r;
    overflow_s = overflow_r;
    case ({push_ok_s, pop_s})
      2'b10:   cnt_s = cnt_r + (PW + 1)'(1);
      2'b01:   cnt_s = cnt_r - (PW + 1)'(1);
      default: cnt_s = cnt_r;
    endcase
    if (push_req_s && !push_ok_s) begin
      overflow_s = 1'b1;
    end else if (ovf_clr_s) begin
      overflow_s = 1'b0;
    end else begin
      overflow_s = overflow_r;
    end
  end

  // Frame FSM state, counters, shifter and registered tx line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
    end
  end

  // FIFO storage, pointers, occupancy count and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      cnt_r      <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= port_wdata[7:0];
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      cnt_r      <= cnt_s;
      overflow_r <= overflow_s;
    end
  end

endmodule

// File: tb/tb_port_uart_tx.sv
// Directed bench for port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line decoder collects transmitted bytes and frame start cycles.
module tb_port_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_write = 1'b0;
  logic        cpu_read = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] port_wdata = 16'h0000;
  logic [15:0] status;
  logic        tx;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mon_en = 1'b1;
  logic [7:0] rx_q[$];
  int rx_t[$];

  port_uart_tx #(
    .DATA_ADDR(16'h0002), .STATUS_ADDR(16'h0003),
    .CLKS_PER_BIT(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cpu_write(cpu_write), .cpu_read(cpu_read),
    .cpu_addr(cpu_addr), .port_wdata(port_wdata), .status(status), .tx(tx)
  );

  always #5 clk = ~clk;

  // Cycle index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: start seen at first cycle low, then one sample per bit.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst_n === 1'b1 && tx === 1'b0) begin
        int t0;
        logic [7:0] b;
        t0 = cyc;
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = tx;
        end
        repeat (4) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin
          bad++;
          $display("FAIL stop_bit: got %b want 1 (byte %h)", tx, b);
        end
        rx_q.push_back(b);
        rx_t.push_back(t0);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || status !== 16'h0000) begin
        bad++;
        $display("FAIL reset_idle: got tx=%b status=%h want tx=1 status=0000", tx, status);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    logic exp_tx;
    logic [15:0] exp_st;
    frame = {1'b1, 8'h55, 1'b0};
    rx_q.delete(); rx_t.delete();
    @(negedge clk);
    cpu_write = 1'b1; cpu_addr = 16'h0002; port_wdata = 16'hFF55;
    @(negedge clk);
    cpu_write = 1'b0;
    total++;
    if (tx !== 1'b1 || status !== 16'h0001) begin
      bad++;
      $display("FAIL single_push: got tx=%b status=%h want tx=1 status=0001", tx, status);
    end
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      exp_tx = (k <= 40) ? frame[(k - 1) / 4] : 1'b1;
      exp_st = (k <= 40) ? 16'h0001 : 16'h0000;
      total++;
      if (tx !== exp_tx || status !== exp_st) begin
        bad++;
        $display("FAIL single_frame k=%0d: got tx=%b status=%h want tx=%b status=%h",
                 k, tx, status, exp_tx, exp_st);
      end
    end
    total++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      bad++;
      $display("FAIL single_rx: got %0d bytes want one byte 55", rx_q.size());
    end
  endtask

  task automatic test_overflow();
    rx_q.delete(); rx_t.delete();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      cpu_write = 1'b1; cpu_addr = 16'h0002; port_wdata = 16'(i);
    end
    @(negedge clk);
    cpu_write = 1'b0;
    total++;
    if (status !== 16'h0007) begin
      bad++;
      $display("FAIL ovf_full_status: got %h want 0007", status);
    end
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 16'h0003;
    total++;
    if (status !== 16'h0007) begin
      bad++;
      $display("FAIL ovf_read1: got %h want 0007", status);
    end
    @(negedge clk);
    total++;
    if (status !== 16'h0003) begin
      bad++;
      $display("FAIL ovf_read2: got %h want 0003", status);
    end
    cpu_read = 1'b0;
    for (int k = 0; k < 400 && rx_q.size() < 5; k++) @(negedge clk);
    repeat (60) @(negedge clk);
    total++;
    if (rx_q.size() != 5) begin
      bad++;
      $display("FAIL ovf_count: got %0d bytes want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (rx_q[i] !== 8'(i + 1)) begin
          bad++;
          $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'(i + 1));
        end
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rx_t[i + 1] - rx_t[i] != 40) begin
          bad++;
          $display("FAIL ovf_gap%0d: got %0d want 40", i, rx_t[i + 1] - rx_t[i]);
        end
      end
    end
    total++;
    if (status !== 16'h0000 || tx !== 1'b1) begin
      bad++;
      $display("FAIL ovf_idle: got status=%h tx=%b want 0000 1", status, tx);
    end
  endtask

  task automatic test_full_pop_push();
    logic [7:0] exp_b [6];
    int e0;
    exp_b[0] = 8'hC3; exp_b[1] = 8'h3C; exp_b[2] = 8'h81;
    exp_b[3] = 8'h7E; exp_b[4] = 8'h0F; exp_b[5] = 8'hAA;
    rx_q.delete(); rx_t.delete();
    e0 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) e0 = cyc;
      cpu_write = 1'b1; cpu_addr = 16'h0002; port_wdata = {8'h00, exp_b[i]};
    end
    @(negedge clk);
    cpu_write = 1'b0;
    total++;
    if (status !== 16'h0003) begin
      bad++;
      $display("FAIL fpp_full: got %h want 0003", status);
    end
    for (int k = 0; k < 100 && cyc != e0 + 40; k++) @(negedge clk);
    cpu_write = 1'b1; cpu_addr = 16'h0002; port_wdata = 16'h00AA;
    @(negedge clk);
    cpu_write = 1'b0;
    total++;
    if (status !== 16'h0003) begin
      bad++;
      $display("FAIL fpp_push_accept: got %h want 0003", status);
    end
    for (int k = 0; k < 400 && rx_q.size() < 6; k++) @(negedge clk);
    repeat (50) @(negedge clk);
    total++;
    if (rx_q.size() != 6) begin
      bad++;
      $display("FAIL fpp_count: got %0d bytes want 6", rx_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (rx_q[i] !== exp_b[i]) begin
          bad++;
          $display("FAIL fpp_byte%0d: got %h want %h", i, rx_q[i], exp_b[i]);
        end
      end
    end
    total++;
    if (status !== 16'h0000) begin
      bad++;
      $display("FAIL fpp_idle: got %h want 0000", status);
    end
  endtask

  task automatic test_async_reset();
    mon_en = 1'b0;
    @(negedge clk);
    cpu_write = 1'b1; cpu_addr = 16'h0002; port_wdata = 16'h0000;
    @(negedge clk);
    cpu_write = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (tx !== 1'b0 || status !== 16'h0001) begin
      bad++;
      $display("FAIL arst_midframe: got tx=%b status=%h want 0 0001", tx, status);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || status !== 16'h0000) begin
      bad++;
      $display("FAIL arst_immediate: got tx=%b status=%h want 1 0000", tx, status);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || status !== 16'h0000) begin
        bad++;
        $display("FAIL arst_after k=%0d: got tx=%b status=%h want 1 0000", k, tx, status);
      end
    end
    mon_en = 1'b1;
  endtask

  task automatic test_other_addr();
    @(negedge clk);
    cpu_write = 1'b1; cpu_addr = 16'h0003; port_wdata = 16'h0041;
    @(negedge clk);
    cpu_addr = 16'h0000; port_wdata = 16'h0042;
    @(negedge clk);
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 16'h0002;
    @(negedge clk);
    cpu_read = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || status !== 16'h0000) begin
        bad++;
        $display("FAIL other_addr k=%0d: got tx=%b status=%h want 1 0000", k, tx, status);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_full_pop_push();
    test_async_reset();
    test_other_addr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
